dccm_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory (DCCM) between the core load/store path and an external requester (boot loader / debug DMA). It sits between the core's data-memory port and DCCM in the top level, grants at most one access per cycle with round-robin fairness, and supports an external lock for multi-word transfers. It also routes 1-cycle-latency read responses back to the owning requester.

---
 rtl/dccm_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 25 ++
 rtl/dccm_arbiter.sv | 99 +++++++++
 tb/tb_dccm_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dccm_arb_pkg.sv
// Shared types and constants for DCCM access arbitration.
// Size codes are common to the core LSU, the arbiter and the DCCM itself.
package dccm_arb_pkg;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_EXT  = 1'b1
    } owner_e;

    // Load/store size codes; bit 2 marks an unsigned load.
    localparam logic [2:0] SIZE_BYTE   = 3'b000;
    localparam logic [2:0] SIZE_HALF   = 3'b001;
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [2:0] SIZE_BYTE_U = 3'b100;
    localparam logic [2:0] SIZE_HALF_U = 3'b101;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker producing a one-hot grant.
// Bit 0 is the core side, bit 1 the external side; a set mask bit removes that input.
module rr_arb2
    import dccm_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_owner_i,
    input  logic [1:0] mask_i,
    output logic [1:0] gnt_o
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req_i & ~mask_i;
        gnt_o    = 2'b00;
        unique case (eligible)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_owner_i == OWNER_EXT) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dccm_arbiter.sv
// Shares the single-ported DCCM between the core LSU and an external requester,
// with round-robin fairness, an external burst lock and read-response routing.
module dccm_arbiter
    import dccm_arb_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,

    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [AddrWidth-1:0] core_addr,
    input  logic [DataWidth-1:0] core_wdata,
    input  logic [2:0]           core_byte_en,
    output logic                 core_gnt,
    output logic                 core_rvalid,

    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic [AddrWidth-1:0] ext_addr,
    input  logic [DataWidth-1:0] ext_wdata,
    input  logic [2:0]           ext_byte_en,
    input  logic                 ext_lock,
    output logic                 ext_gnt,
    output logic                 ext_rvalid,

    output logic [DataWidth-1:0] rdata,

    output logic                 dccm_read_en,
    output logic                 dccm_write_en,
    output logic [2:0]           dccm_byte_en,
    output logic [AddrWidth-1:0] dccm_addr,
    output logic [DataWidth-1:0] dccm_wdata,
    input  logic [DataWidth-1:0] dccm_rdata
);

    owner_e     last_owner_q, last_owner_d;
    owner_e     rsp_owner_q, rsp_owner_d;
    logic       locked_q, locked_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [1:0] grantVec;
    logic       anyGnt;
    logic       selWe;
    owner_e     winner;

    rr_arb2 u_rr_arb2 (
        .req_i        ({ext_req, core_req}),
        .last_owner_i (last_owner_q),
        .mask_i       ({1'b0, locked_q}),
        .gnt_o        (grantVec)
    );

    // Grants are held off while reset is asserted so no strobe can reach the DCCM.
    assign core_gnt = grantVec[0] & brq_rst;
    assign ext_gnt  = grantVec[1] & brq_rst;
    assign anyGnt   = core_gnt | ext_gnt;
    assign winner   = ext_gnt ? OWNER_EXT : OWNER_CORE;
    assign selWe    = ext_gnt ? ext_we : core_we;

    assign dccm_read_en  = anyGnt & ~selWe;
    assign dccm_write_en = anyGnt & selWe;
    assign dccm_byte_en  = ext_gnt ? ext_byte_en : core_byte_en;
    assign dccm_addr     = ext_gnt ? ext_addr    : core_addr;
    assign dccm_wdata    = ext_gnt ? ext_wdata   : core_wdata;

    assign rdata       = dccm_rdata;
    assign core_rvalid = rsp_valid_q & (rsp_owner_q == OWNER_CORE);
    assign ext_rvalid  = rsp_valid_q & (rsp_owner_q == OWNER_EXT);

    // Dropping ext_lock releases the lock at the next edge even if ext is granted that cycle.
    always_comb begin
        last_owner_d = anyGnt ? winner : last_owner_q;
        locked_d     = locked_q;
        if (!ext_lock) begin
            locked_d = 1'b0;
        end else if (ext_gnt) begin
            locked_d = 1'b1;
        end
        rsp_valid_d = dccm_read_en;
        rsp_owner_d = winner;
    end

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            last_owner_q <= OWNER_EXT;
            locked_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= OWNER_CORE;
        end else begin
            last_owner_q <= last_owner_d;
            locked_q     <= locked_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
        end
    end

endmodule

// File: tb/tb_dccm_arbiter.sv
// Self-checking bench for dccm_arbiter with a behavioural DCCM and a response scoreboard.
module tb_dccm_arbiter;
    import dccm_arb_pkg::*;

    typedef struct {
        owner_e      owner;
        logic [31:0] data;
        int          cycle;
    } sbEntry_t;

    logic        clock;
    logic        rstN;
    logic        coreReq, coreWe;
    logic [14:0] coreAddr;
    logic [31:0] coreWdata;
    logic [2:0]  coreBe;
    logic        extReq, extWe, extLock;
    logic [14:0] extAddr;
    logic [31:0] extWdata;
    logic [2:0]  extBe;
    logic        core_gnt, core_rvalid, ext_gnt, ext_rvalid;
    logic [31:0] rdata;
    logic        dccm_read_en, dccm_write_en;
    logic [2:0]  dccm_byte_en;
    logic [14:0] dccm_addr;
    logic [31:0] dccm_wdata;
    logic [31:0] dccm_rdata;

    logic [31:0] dccmMem [0:32767];
    logic [31:0] refMem  [0:32767];
    sbEntry_t    sbQ[$];
    int          cyc;
    int          testsRun;
    int          testsFailed;

    dccm_arbiter #(.DataWidth(32), .AddrWidth(15)) dut (
        .brq_clk       (clock),
        .brq_rst       (rstN),
        .core_req      (coreReq),
        .core_we       (coreWe),
        .core_addr     (coreAddr),
        .core_wdata    (coreWdata),
        .core_byte_en  (coreBe),
        .core_gnt      (core_gnt),
        .core_rvalid   (core_rvalid),
        .ext_req       (extReq),
        .ext_we        (extWe),
        .ext_addr      (extAddr),
        .ext_wdata     (extWdata),
        .ext_byte_en   (extBe),
        .ext_lock      (extLock),
        .ext_gnt       (ext_gnt),
        .ext_rvalid    (ext_rvalid),
        .rdata         (rdata),
        .dccm_read_en  (dccm_read_en),
        .dccm_write_en (dccm_write_en),
        .dccm_byte_en  (dccm_byte_en),
        .dccm_addr     (dccm_addr),
        .dccm_wdata    (dccm_wdata),
        .dccm_rdata    (dccm_rdata)
    );

    // Free-running clock with a cycle counter used to time-stamp scoreboard entries.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural single-ported DCCM with one-cycle read latency.
    always @(posedge clock) begin
        if (dccm_write_en) dccmMem[dccm_addr] <= dccm_wdata;
        if (dccm_read_en)  dccm_rdata <= dccmMem[dccm_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic isExt, input logic req, input logic we,
                                 input logic [14:0] addr, input logic [31:0] wdata, input logic [2:0] be);
        if (isExt) begin
            extReq = req; extWe = we; extAddr = addr; extWdata = wdata; extBe = be;
        end else begin
            coreReq = req; coreWe = we; coreAddr = addr; coreWdata = wdata; coreBe = be;
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Checks the grant pair the bench expects, then records writes in the reference
    // memory and pushes the expected response for reads.
    task automatic expectGrant(input string tag, input logic expCore, input logic expExt);
        sbEntry_t e;
        checkOutput({tag, "_coreGnt"}, {31'd0, core_gnt}, {31'd0, expCore});
        checkOutput({tag, "_extGnt"},  {31'd0, ext_gnt},  {31'd0, expExt});
        if (expCore) begin
            if (coreWe) refMem[coreAddr] = coreWdata;
            else begin
                e.owner = OWNER_CORE; e.data = refMem[coreAddr]; e.cycle = cyc;
                sbQ.push_back(e);
            end
        end
        if (expExt) begin
            if (extWe) refMem[extAddr] = extWdata;
            else begin
                e.owner = OWNER_EXT; e.data = refMem[extAddr]; e.cycle = cyc;
                sbQ.push_back(e);
            end
        end
    endtask

    // Response monitor: a response is due exactly one cycle after its read grant.
    always @(negedge clock) begin
        sbEntry_t e;
        if (sbQ.size() > 0 && sbQ[0].cycle == cyc - 1) begin
            e = sbQ.pop_front();
            checkOutput("coreRvalid", {31'd0, core_rvalid}, {31'd0, e.owner == OWNER_CORE});
            checkOutput("extRvalid",  {31'd0, ext_rvalid},  {31'd0, e.owner == OWNER_EXT});
            checkOutput("rdata", rdata, e.data);
        end else begin
            checkOutput("rvIdle", {30'd0, core_rvalid, ext_rvalid}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun = 0;
        testsFailed = 0;
        for (int i = 0; i < 32768; i++) begin
            dccmMem[i] = 32'd0;
            refMem[i]  = 32'd0;
        end
        dccm_rdata = 32'd0;
        rstN = 1'b0;
        extLock = 1'b0;
        applyStimulus(0, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        applyStimulus(1, 0, 0, 15'h0, 32'h0, SIZE_WORD);

        // Both ports request reads from reset onward; grants must alternate starting with core.
        nextCycle();
        applyStimulus(0, 1, 0, 15'h0003, 32'h0, SIZE_WORD);
        applyStimulus(1, 1, 0, 15'h0004, 32'h0, SIZE_WORD);
        @(negedge clock);
        checkOutput("rstCoreGnt", {31'd0, core_gnt}, 32'd0);
        checkOutput("rstExtGnt",  {31'd0, ext_gnt},  32'd0);
        checkOutput("rstStrobes", {30'd0, dccm_read_en, dccm_write_en}, 32'd0);
        nextCycle();
        rstN = 1'b1;
        @(negedge clock);
        expectGrant("rr0", 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) begin
            nextCycle();
            @(negedge clock);
            expectGrant($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        applyStimulus(1, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);

        // Core-only write then read of 0x0010.
        nextCycle();
        applyStimulus(0, 1, 1, 15'h0010, 32'hDEADBEEF, SIZE_WORD);
        @(negedge clock);
        expectGrant("t1wr", 1'b1, 1'b0);
        checkOutput("t1wrEn", {31'd0, dccm_write_en}, 32'd1);
        nextCycle();
        applyStimulus(0, 1, 0, 15'h0010, 32'h0, SIZE_WORD);
        @(negedge clock);
        expectGrant("t1rd", 1'b1, 1'b0);
        checkOutput("t1rdEn", {31'd0, dccm_read_en}, 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);

        // ext_lock without an ext grant must not block the core.
        nextCycle();
        extLock = 1'b1;
        applyStimulus(0, 1, 0, 15'h0010, 32'h0, SIZE_WORD);
        @(negedge clock);
        expectGrant("noLock0", 1'b1, 1'b0);
        nextCycle();
        @(negedge clock);
        expectGrant("noLock1", 1'b1, 1'b0);

        // Locked 4-word ext burst while the core keeps requesting; lock dropped with the last word.
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            extLock = (i != 3);
            applyStimulus(1, 1, 1, 15'h0100 + 15'(i), 32'hA000_0000 + i, SIZE_WORD);
            @(negedge clock);
            expectGrant($sformatf("lock%0d", i), 1'b0, 1'b1);
        end
        nextCycle();
        applyStimulus(1, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);
        expectGrant("afterLock", 1'b1, 1'b0);
        nextCycle();
        applyStimulus(0, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);

        // Interleaved reads of two distinct words, core then ext.
        nextCycle();
        applyStimulus(0, 1, 1, 15'h0001, 32'h11111111, SIZE_WORD);
        @(negedge clock);
        expectGrant("ilWrC", 1'b1, 1'b0);
        nextCycle();
        applyStimulus(0, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        applyStimulus(1, 1, 1, 15'h0002, 32'h22222222, SIZE_WORD);
        @(negedge clock);
        expectGrant("ilWrE", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(0, 1, 0, 15'h0001, 32'h0, SIZE_WORD);
        applyStimulus(1, 1, 0, 15'h0002, 32'h0, SIZE_WORD);
        @(negedge clock);
        expectGrant("ilRdC", 1'b1, 1'b0);
        nextCycle();
        applyStimulus(0, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);
        expectGrant("ilRdE", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);

        // Ext unsigned-byte store: size code and address must come from the ext port.
        nextCycle();
        applyStimulus(1, 1, 1, 15'h0123, 32'h000000A5, SIZE_BYTE_U);
        @(negedge clock);
        expectGrant("byteSt", 1'b0, 1'b1);
        checkOutput("byteBe",   {29'd0, dccm_byte_en}, {29'd0, SIZE_BYTE_U});
        checkOutput("byteAddr", {17'd0, dccm_addr}, 32'h0123);
        checkOutput("byteStrb", {30'd0, dccm_read_en, dccm_write_en}, 32'd1);
        nextCycle();
        applyStimulus(1, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);

        // Reset right after a core read grant discards the response and restores core priority.
        nextCycle();
        applyStimulus(0, 1, 0, 15'h0010, 32'h0, SIZE_WORD);
        @(negedge clock);
        expectGrant("preRst", 1'b1, 1'b0);
        nextCycle();
        rstN = 1'b0;
        sbQ.delete();
        applyStimulus(1, 1, 0, 15'h0002, 32'h0, SIZE_WORD);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            expectGrant($sformatf("inRst%0d", i), 1'b0, 1'b0);
            nextCycle();
        end
        rstN = 1'b1;
        @(negedge clock);
        expectGrant("postRst", 1'b1, 1'b0);
        nextCycle();
        applyStimulus(0, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);
        expectGrant("postRstE", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1, 0, 0, 15'h0, 32'h0, SIZE_WORD);
        @(negedge clock);
        nextCycle();
        @(negedge clock);
        checkOutput("sbEmpty", sbQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
